// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo
//   Byte FIFO plus start sequencer that sits directly in front of SerialTx.
//   A producer pushes bytes at any rate.  The block pops one byte at a time,
//   presents it on tx_data and raises tx_ce until SerialTx answers with
//   tx_busy.  It then waits for tx_busy to fall before it starts the next byte.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-low (0 = reset)
//   wr_en     in   push wr_data this cycle
//   wr_data   in   byte to enqueue
//   full      out  FIFO holds 2**DEPTH_LOG2 entries
//   empty     out  FIFO holds no entries
//   level     out  current entry count
//   overflow  out  sticky: a push was attempted while full
//   tx_data   out  SerialTx data (registered, held until the next pop)
//   tx_ce     out  SerialTx start strobe (registered)
//   tx_busy   in   SerialTx busy
//   timeout   out  sticky: SerialTx never acknowledged a start
//
// Build option
//   SERIAL_TX_FIFO_TIMEOUT_EN : when defined, a start that is not acknowledged
//   within TIMEOUT cycles is abandoned and flagged on timeout.  When it is
//   undefined, the block waits for tx_busy indefinitely and timeout reads 0.
module serial_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ce,
  input  logic                  tx_busy,
  output logic                  timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0]     wr_ptr, rd_ptr;
  logic                    push, pop;
  logic                    tx_ce_d;
  logic                    to_expire;

  // The extra pointer MSB tells a full buffer (MSBs differ) from an empty one.
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // full is taken before this cycle's pop, so a simultaneous pop never makes room.
  assign push = wr_en && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_ce_d = tx_ce;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          tx_ce_d = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          tx_ce_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (to_expire) begin
          // Abandon this byte; the next one can pop on the following edge.
          tx_ce_d = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_ce_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state_q  <= IDLE;
      tx_ce    <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_ce   <= tx_ce_d;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SERIAL_TX_FIFO_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] wait_cnt;
  logic            timeout_q;

  // wait_cnt counts idle-busy cycles already spent in WAIT_BUSY; the
  // TIMEOUT-th such cycle gives up.
  assign to_expire = (state_q == WAIT_BUSY) && !tx_busy &&
                     (wait_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (pop) begin
        wait_cnt <= '0;
      end else if ((state_q == WAIT_BUSY) && !tx_busy && !to_expire) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (to_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign to_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
